seq_1011_tx: RTL and testbench
==============================

Name: seq_1011_tx

Overview:
- Serial frame transmitter: the sending end of the "1011"-framed serial link.
- Accepts a parallel word over a valid/ready handshake.
- Emits sync preamble 1011 on a 1-bit line, then the data MSB-first, then an optional even-parity bit.
- Feeds the serial pattern detector / frame receiver downstream; one bit per clk.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- PAT_W, 4, preamble length in bits.
- PATTERN, 4'b1011, preamble value; MSB sent first.
- PARITY_EN, 1, 1 = append even-parity bit after data; 0 = no parity bit.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_valid  in  1  source has a word on tx_data.
- tx_data  in  DATA_W  payload word.
- tx_ready  out  1  block can accept a word this cycle.
- dout  out  1  serial line.
- dout_en  out  1  dout carries a frame bit this cycle.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse coinciding with the last frame bit.

Behaviour:
- Reset (reset=0, async): state IDLE, dout=0, dout_en=0, tx_ready=1, busy=0, done=0, counter and shift register cleared. Applies immediately, including mid-frame; the partial frame is abandoned, not resumed.
- All outputs are registered or decoded only from registered state; no combinational path from tx_valid or tx_data to any output.
- States, 2-bit encoding:
  - IDLE: tx_ready=1, dout=0, dout_en=0, busy=0.
  - PRE: sends PATTERN bits PAT_W-1 down to 0.
  - DATA: sends the latched word, MSB first.
  - PAR: sends ^data_latched (even parity: count of ones over data+parity bit is even).
- Acceptance: tx_valid & tx_ready at rising edge E0. At E0 tx_data is latched into the shift register and state goes to PRE.
- First preamble bit is on dout in the cycle after E0; dout_en=1 and busy=1 from that cycle.
- Frame length L = PAT_W + DATA_W + PARITY_EN cycles; bits occupy the cycles after edges E0 .. E(L-1).
- Transitions:
  - PRE -> DATA after PAT_W bits.
  - DATA -> PAR after DATA_W bits when PARITY_EN=1.
  - DATA -> IDLE after DATA_W bits when PARITY_EN=0.
  - PAR -> IDLE after 1 bit.
- done=1 only during the final bit cycle.
- After edge EL: IDLE, tx_ready=1, dout_en=0.
- Back-to-back frames: tx_valid held high starts the next frame at E(L+1), so there is exactly one idle cycle (dout=0, dout_en=0) between frames. This gap is mandatory.
- tx_valid while busy is ignored (tx_ready=0); no queuing.
- tx_data changes after E0 do not affect the frame in flight.
- Bit counter width: clog2(max(PAT_W, DATA_W)) + 1. The counter reloads at each state change and never wraps within a state.
- Payload bits equal to PATTERN are sent unescaped; false preamble matches inside the payload are the receiver's concern.
- Illegal/unused state encoding: treated as IDLE on the next edge.

Decomposition:
- Shared package seq_tx_pkg:
  - state enum (IDLE=2'b00, PRE=2'b01, DATA=2'b10, PAR=2'b11).
  - SYNC_PATTERN=4'b1011 and SYNC_W=4, shared with the receiver.
  - function for even parity.
- One sub-module, piso_shift: parameterised parallel-in serial-out shift register with load, shift enable and MSB output, used for the payload.
- Preamble is selected by indexing PATTERN with the bit counter; no second shift register.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> dout=0, dout_en=0, tx_ready=1, busy=0, done=0. Release, no tx_valid for 5 cycles -> outputs unchanged.
- Single frame, DATA_W=8, PARITY_EN=1, tx_data=8'hA5 accepted at E0:
  - dout over the 13 cycles after E0..E12 is 1,0,1,1,1,0,1,0,0,1,0,1,0.
  - dout_en=1 exactly for those 13 cycles; done=1 only in the 13th.
  - tx_ready=1 after E13.
- Parity check, tx_data=8'h01 -> parity bit 1. PARITY_EN=0 build with 8'h01 -> 12-bit frame 1011_00000001, done on bit 12, no parity cycle.
- Busy/stability:
  - Accept 8'h3C, then during the frame pulse tx_valid with 8'hFF and change tx_data to 8'h00.
  - Required: frame still carries 3C (1011_00111100_0); 8'hFF never transmitted.
  - tx_ready=0 throughout the frame.
- Reset mid-frame: accept 8'hA5, assert reset=0 during the 6th bit -> all outputs at reset values immediately. Release and send 8'h5A -> clean frame 1011_01011010_0.
- Back-to-back: tx_valid held 1 with 8'h3C then 8'hC3 -> two 13-bit frames separated by exactly one cycle with dout_en=0. done pulses twice.
- Loopback: output into the team's 1011 frame receiver -> payloads 8'hA5 and 8'h3C recovered.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared definitions for the 1011-framed serial link: the transmitter state
// encoding, the sync preamble used by both ends, and the parity helper.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PRE  = 2'b01,
    DATA = 2'b10,
    PAR  = 2'b11
  } tx_state_t;

  localparam int SYNC_W = 4;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011;

  // Wide enough for any payload on this link; callers zero-extend.
  localparam int PARITY_MAX_W = 64;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic evenParity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/seq_1011_tx_piso_shift.sv
// Parallel-in serial-out shift register: loads a word, then presents it
// MSB first, moving one bit per enabled clock.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_shreg;

  // Load takes priority so a new frame can never inherit stale payload bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= r_shreg << 1;
    end
  end

  assign o_msb = r_shreg[W-1];

endmodule

// File: rtl/seq_1011_tx.sv
// Serial frame transmitter: accepts a word over valid/ready, then sends the
// sync preamble, the payload MSB first and an optional even-parity bit.
module seq_1011_tx
  import seq_tx_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                PAT_W     = SYNC_W,
  parameter logic [PAT_W-1:0]  PATTERN   = SYNC_PATTERN,
  parameter bit                PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              busy,
  output logic              done
);

  localparam int MAX_W  = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int CNT_W  = $clog2(MAX_W) + 1;
  localparam int PIDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  tx_state_t         r_state;
  tx_state_t         w_nextState;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [CNT_W-1:0]  w_nextCnt;
  logic              r_parity;
  logic              w_load;
  logic              w_shift;
  logic              w_payloadMsb;
  logic [PIDX_W-1:0] w_patIdx;

  // The counter runs down from PAT_W-1 in PRE, so it doubles as the preamble index.
  assign w_patIdx = r_bitCnt[PIDX_W-1:0];

  piso_shift #(
    .W(DATA_W)
  ) u_payload (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_data (tx_data),
    .o_msb  (w_payloadMsb)
  );

  // Parity is captured at acceptance because the shift register is consumed as it sends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_bitCnt <= w_nextCnt;
      if (w_load) begin
        r_parity <= evenParity(PARITY_MAX_W'(tx_data));
      end
    end
  end

  // Outputs depend only on registered state; tx_valid steers the next state alone.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_bitCnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    tx_ready    = 1'b0;
    dout        = 1'b0;
    dout_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          w_nextState = PRE;
          w_nextCnt   = PRE_LAST;
          w_load      = 1'b1;
        end
      end
      PRE: begin
        dout    = PATTERN[w_patIdx];
        dout_en = 1'b1;
        busy    = 1'b1;
        if (r_bitCnt == '0) begin
          w_nextState = DATA;
          w_nextCnt   = DATA_LAST;
        end else begin
          w_nextCnt = r_bitCnt - CNT_W'(1);
        end
      end
      DATA: begin
        dout    = w_payloadMsb;
        dout_en = 1'b1;
        busy    = 1'b1;
        w_shift = 1'b1;
        if (r_bitCnt == '0) begin
          w_nextCnt = '0;
          if (PARITY_EN) begin
            w_nextState = PAR;
          end else begin
            w_nextState = IDLE;
            done        = 1'b1;
          end
        end else begin
          w_nextCnt = r_bitCnt - CNT_W'(1);
        end
      end
      PAR: begin
        dout        = r_parity;
        dout_en     = 1'b1;
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_1011_tx.sv
// Bench for seq_1011_tx: a parity and a no-parity instance share stimulus and
// are compared every cycle against a frame-position model, plus literal frames.
module tb_seq_1011_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic readyP, doutP, enP, busyP, doneP;
  logic readyN, doutN, enN, busyN, doneN;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_1011_tx #(
    .DATA_W(8), .PAT_W(4), .PATTERN(4'b1011), .PARITY_EN(1'b1)
  ) dutP (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(readyP), .dout(doutP), .dout_en(enP), .busy(busyP), .done(doneP)
  );

  seq_1011_tx #(
    .DATA_W(8), .PAT_W(4), .PATTERN(4'b1011), .PARITY_EN(1'b0)
  ) dutN (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(readyN), .dout(doutN), .dout_en(enN), .busy(busyN), .done(doneN)
  );

  // Reference model: a frame is a bit string; the model only tracks whether a
  // frame is in flight and which bit of it is on the line this cycle.
  bit          mActive[2];
  int          mPos[2];
  int          mLen[2];
  logic [12:0] mBits[2];

  function automatic logic [12:0] frameOf(input logic [7:0] d, input bit withParity);
    int   ones;
    logic parBit;
    ones   = $countones(d);
    parBit = ((ones % 2) != 0);
    if (withParity) return {4'b1011, d, parBit};
    return {1'b0, 4'b1011, d};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mActive[i] <= 1'b0;
        mPos[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mActive[i]) begin
          if (mPos[i] == mLen[i] - 1) mActive[i] <= 1'b0;
          else mPos[i] <= mPos[i] + 1;
        end else if (tx_valid) begin
          mActive[i] <= 1'b1;
          mPos[i]    <= 0;
          mLen[i]    <= (i == 0) ? 13 : 12;
          mBits[i]   <= frameOf(tx_data, i == 0);
        end
      end
    end
  end

  // Frame recorders: collect every completed frame seen on each serial line.
  logic [12:0] curP = '0, curN = '0;
  int          curLenP = 0, curLenN = 0;
  int          gapRunP = 0, startGapP = 0;
  logic [12:0] framesP[$];
  logic [12:0] framesN[$];
  int          lensP[$];
  int          lensN[$];
  int          gapsP[$];

  always @(negedge clk) begin
    if (!reset) begin
      curP    <= '0;
      curLenP <= 0;
      gapRunP <= 0;
    end else if (enP) begin
      if (curLenP == 0) startGapP <= gapRunP;
      gapRunP <= 0;
      if (doneP) begin
        framesP.push_back({curP[11:0], doutP});
        lensP.push_back(curLenP + 1);
        gapsP.push_back((curLenP == 0) ? gapRunP : startGapP);
        curP    <= '0;
        curLenP <= 0;
      end else begin
        curP    <= {curP[11:0], doutP};
        curLenP <= curLenP + 1;
      end
    end else begin
      gapRunP <= gapRunP + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      curN    <= '0;
      curLenN <= 0;
    end else if (enN) begin
      if (doneN) begin
        framesN.push_back({curN[11:0], doutN});
        lensN.push_back(curLenN + 1);
        curN    <= '0;
        curLenN <= 0;
      end else begin
        curN    <= {curN[11:0], doutN};
        curLenN <= curLenN + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic compareDut(input int i, input string tag, input logic dout,
                            input logic en, input logic bsy, input logic rdy,
                            input logic dn);
    logic expDout;
    expDout = mActive[i] ? mBits[i][mLen[i] - 1 - mPos[i]] : 1'b0;
    checkOutput({tag, ".dout"}, 32'(dout), 32'(expDout));
    checkOutput({tag, ".dout_en"}, 32'(en), 32'(mActive[i]));
    checkOutput({tag, ".busy"}, 32'(bsy), 32'(mActive[i]));
    checkOutput({tag, ".tx_ready"}, 32'(rdy), 32'(!mActive[i]));
    checkOutput({tag, ".done"}, 32'(dn),
                32'(mActive[i] && (mPos[i] == mLen[i] - 1)));
  endtask

  // One clock: compare both DUTs against the model mid-cycle, then move to
  // just after the next rising edge where inputs are driven.
  task automatic stepCycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      compareDut(0, "par", doutP, enP, busyP, readyP, doneP);
      compareDut(1, "nopar", doutN, enN, busyN, readyN, doneN);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int tailCycles);
    tx_valid = 1'b1;
    tx_data  = d;
    stepCycle(1);
    tx_valid = 1'b0;
    stepCycle(tailCycles);
  endtask

  task automatic checkIdleLiterals(input string name);
    checkOutput({name, ".par.idle"}, {27'd0, doutP, enP, busyP, doneP, readyP}, 32'h1);
    checkOutput({name, ".nopar.idle"}, {27'd0, doutN, enN, busyN, doneN, readyN}, 32'h1);
  endtask

  int baseP, baseN;

  initial begin
    #1 reset = 1'b0;
    @(posedge clk);
    #2;
    $display("[TB] reset phase");
    stepCycle(3);
    checkIdleLiterals("reset_hold");
    reset = 1'b1;
    stepCycle(5);
    checkIdleLiterals("post_reset");

    $display("[TB] single frame A5");
    baseP = framesP.size();
    applyStimulus(8'hA5, 14);
    checkOutput("a5.count", 32'(framesP.size() - baseP), 32'd1);
    if (framesP.size() > baseP) begin
      checkOutput("a5.frame", 32'(framesP[baseP]), 32'b1011_1010_0101_0);
      checkOutput("a5.len", 32'(lensP[baseP]), 32'd13);
      checkOutput("loopback.a5", 32'(framesP[baseP][8:1]), 32'hA5);
    end
    checkOutput("a5.ready_after", 32'(readyP), 32'd1);

    $display("[TB] parity frame 01");
    baseP = framesP.size();
    baseN = framesN.size();
    applyStimulus(8'h01, 14);
    if (framesP.size() > baseP)
      checkOutput("p01.frame", 32'(framesP[baseP]), 32'b1011_0000_0001_1);
    else checkOutput("p01.count", 32'(framesP.size() - baseP), 32'd1);
    if (framesN.size() > baseN) begin
      checkOutput("n01.frame", 32'(framesN[baseN]), 32'b1011_0000_0001);
      checkOutput("n01.len", 32'(lensN[baseN]), 32'd12);
    end else checkOutput("n01.count", 32'(framesN.size() - baseN), 32'd1);

    $display("[TB] busy stability 3C");
    baseP = framesP.size();
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    stepCycle(1);
    tx_valid = 1'b0;
    stepCycle(3);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    checkOutput("busy.ready", 32'(readyP), 32'd0);
    stepCycle(1);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    stepCycle(13);
    checkOutput("busy.count", 32'(framesP.size() - baseP), 32'd1);
    if (framesP.size() > baseP)
      checkOutput("busy.frame", 32'(framesP[baseP]), 32'b1011_0011_1100_0);

    $display("[TB] reset mid-frame");
    baseP = framesP.size();
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    stepCycle(1);
    tx_valid = 1'b0;
    stepCycle(5);
    reset = 1'b0;
    #1;
    checkIdleLiterals("midreset");
    stepCycle(2);
    reset = 1'b1;
    stepCycle(1);
    applyStimulus(8'h5A, 14);
    checkOutput("midreset.count", 32'(framesP.size() - baseP), 32'd1);
    if (framesP.size() > baseP)
      checkOutput("midreset.frame", 32'(framesP[baseP]), 32'b1011_0101_1010_0);

    $display("[TB] back-to-back 3C C3");
    baseP = framesP.size();
    baseN = framesN.size();
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    stepCycle(1);
    tx_data = 8'hC3;
    stepCycle(14);
    tx_valid = 1'b0;
    stepCycle(15);
    checkOutput("b2b.count", 32'(framesP.size() - baseP), 32'd2);
    checkOutput("b2b.nopar_count", 32'(framesN.size() - baseN), 32'd2);
    if (framesP.size() >= baseP + 2) begin
      checkOutput("b2b.frame1", 32'(framesP[baseP]), 32'b1011_0011_1100_0);
      checkOutput("b2b.frame2", 32'(framesP[baseP + 1]), 32'b1011_1100_0011_0);
      checkOutput("b2b.gap", 32'(gapsP[baseP + 1]), 32'd1);
      checkOutput("loopback.3c", 32'(framesP[baseP][8:1]), 32'h3C);
    end

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      tx_valid = ($urandom_range(0, 9) < 7);
      tx_data  = 8'($urandom);
      reset    = ($urandom_range(0, 59) != 0);
      stepCycle(1);
    end
    reset    = 1'b1;
    tx_valid = 1'b0;
    stepCycle(16);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
